shift_rows_pipe: RTL

SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

---
 rtl/aes_pkg.sv | 31 +++
 rtl/shift_rows_perm.sv | 35 +++
 rtl/shift_rows_pipe.sv | 100 ++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared ShiftRows mode encodings and per-NB row offset table
package aes_pkg;

    typedef enum logic [1:0] {
        MODE_FWD     = 2'b00,
        MODE_INV     = 2'b01,
        MODE_BYP     = 2'b10,
        MODE_BYP_ALT = 2'b11
    } sr_mode_e;

    localparam int ROWS = 4;

    // Row offsets packed as [row] -> shift amount; 256-bit blocks widen rows 2 and 3.
    localparam logic [3:0][2:0] OFF_NB4_6 = {3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [3:0][2:0] OFF_NB8   = {3'd4, 3'd3, 3'd1, 3'd0};

    function automatic int row_offset(input int nb, input int r);
        logic [2:0] off;
        if (nb == 8) begin
            off = OFF_NB8[r];
        end else begin
            off = OFF_NB4_6[r];
        end
        return int'(off);
    endfunction

    function automatic bit nb_legal(input int nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// rtl/shift_rows_perm.sv - combinational Rijndael ShiftRows / InvShiftRows / bypass permutation
module shift_rows_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic [32*NB-1:0] data_i,
    input  logic [1:0]       mode_i,
    output logic [32*NB-1:0] data_o
);

    logic [32*NB-1:0] fwd;
    logic [32*NB-1:0] inv;

    // Byte (r,c) sits at index 4*c+r; each output byte is pure wiring from its source column.
    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            localparam int OFF = row_offset(NB, r);
            localparam int SF  = (c + OFF) % NB;
            localparam int SI  = (c + NB - OFF) % NB;
            assign fwd[8*(4*c+r) +: 8] = data_i[8*(4*SF+r) +: 8];
            assign inv[8*(4*c+r) +: 8] = data_i[8*(4*SI+r) +: 8];
        end
    end

    always_comb begin
        data_o = data_i;
        case (sr_mode_e'(mode_i))
            MODE_FWD: data_o = fwd;
            MODE_INV: data_o = inv;
            default:  data_o = data_i;
        endcase
    end

endmodule

// File: rtl/shift_rows_pipe.sv
// rtl/shift_rows_pipe.sv - ShiftRows stage with a registered 2-entry skid buffer
module shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int NB = 4,
    parameter int W  = 32 * NB
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic [W-1:0] in_data,
    input  logic [1:0]   in_mode,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   level
);

    if (!nb_legal(NB) || (W != 32 * NB)) begin : g_bad_nb
        $fatal(1, "shift_rows_pipe: NB must be 4, 6 or 8 and W must equal 32*NB");
    end

    logic [W-1:0] perm_data;

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] skid_q, skid_d;
    logic         head_v_q, head_v_d;
    logic         skid_v_q, skid_v_d;
    logic         in_ready_q, in_ready_d;
    logic [1:0]   level_d;
    logic         accept;
    logic         deliver;

    // The mode travels with its beat by permuting before storage.
    shift_rows_perm #(
        .NB(NB)
    ) u_perm (
        .data_i (in_data),
        .mode_i (in_mode),
        .data_o (perm_data)
    );

    assign accept  = in_valid && in_ready_q;
    assign deliver = head_v_q && out_ready;

    always_comb begin
        head_d   = head_q;
        skid_d   = skid_q;
        head_v_d = head_v_q;
        skid_v_d = skid_v_q;
        if (deliver) begin
            if (skid_v_q) begin
                head_d   = skid_q;
                head_v_d = 1'b1;
                skid_v_d = accept;
                if (accept) begin
                    skid_d = perm_data;
                end
            end else begin
                head_v_d = accept;
                if (accept) begin
                    head_d = perm_data;
                end
            end
        end else if (accept) begin
            if (!head_v_q) begin
                head_d   = perm_data;
                head_v_d = 1'b1;
            end else begin
                skid_d   = perm_data;
                skid_v_d = 1'b1;
            end
        end
        level_d    = {1'b0, head_v_d} + {1'b0, skid_v_d};
        in_ready_d = (level_d < 2'd2);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            head_q     <= '0;
            skid_q     <= '0;
            head_v_q   <= 1'b0;
            skid_v_q   <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            skid_q     <= skid_d;
            head_v_q   <= head_v_d;
            skid_v_q   <= skid_v_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign out_data  = head_q;
    assign out_valid = head_v_q;
    assign in_ready  = in_ready_q;
    assign level     = {1'b0, head_v_q} + {1'b0, skid_v_q};

endmodule
